// File: rtl/modbus_rsp_scheduler_pkg.sv
// Shared types and helpers for the Modbus RTU response scheduler.
package modbus_rsp_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_LEAD,
        ST_START,
        ST_TX,
        ST_TAIL
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_EXP,
        SEL_06,
        SEL_0304
    } sel_t;

    localparam int CHAR_BITS = 11;

    function automatic logic [1:0] count_reqs(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/modbus_rsp_scheduler_cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module mb_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/modbus_rsp_scheduler.sv
// RS485 response scheduler: one grant per busy period, inter-frame gap, driver guard times,
// transmit watchdog and a saturating count of requests lost to contention.
//
//  state | meaning
//  IDLE  | bus released, waiting for a response request
//  GAP   | turnaround gap; receiver activity restarts it
//  LEAD  | driver enabled ahead of the first start bit
//  START | one-cycle grant pulse to the tx engine
//  TX    | tx engine owns the line, watchdog running
//  TAIL  | driver held after the last stop bit
module modbus_rsp_scheduler
    import modbus_rsp_scheduler_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int GAP_BITS  = 38,
    parameter int MAX_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_state,
    input  logic       req_exp,
    input  logic       req_06,
    input  logic       req_03_04,
    input  logic       tx_done,
    output logic       start_exp,
    output logic       start_06,
    output logic       start_03_04,
    output logic       rs485_oe,
    output logic       busy,
    output logic       tx_timeout,
    output logic [7:0] drop_cnt
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int GAP_CYC = BIT_CYC * GAP_BITS;
    localparam int TMO_CYC = BIT_CYC * CHAR_BITS * MAX_BYTES;
    localparam int TW      = $clog2(TMO_CYC + 1);

    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] BIT_LD = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] TMO_LD = TW'(TMO_CYC - 1);

    state_t          state, state_n;
    sel_t            sel, sel_n;
    logic            tmr_load;
    logic [TW-1:0]   tmr_value;
    logic            tmr_zero;
    logic            timeout_n;
    logic [1:0]      nreq;
    logic [1:0]      drop_inc;

    mb_cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign nreq = count_reqs(req_exp, req_06, req_03_04);

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        tmr_load  = 1'b0;
        tmr_value = GAP_LD;
        timeout_n = 1'b0;
        drop_inc  = nreq;
        case (state)
            ST_IDLE: begin
                if (nreq != 2'd0) begin
                    state_n   = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LD;
                    drop_inc  = nreq - 2'd1;
                    if (req_exp)     sel_n = SEL_EXP;
                    else if (req_06) sel_n = SEL_06;
                    else             sel_n = SEL_0304;
                end
            end
            ST_GAP: begin
                // Receiver activity means the master is still talking: restart the full gap.
                if (rx_state) begin
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LD;
                end else if (tmr_zero) begin
                    state_n   = ST_LEAD;
                    tmr_load  = 1'b1;
                    tmr_value = BIT_LD;
                end
            end
            ST_LEAD: begin
                if (tmr_zero) state_n = ST_START;
            end
            ST_START: begin
                state_n   = ST_TX;
                tmr_load  = 1'b1;
                tmr_value = TMO_LD;
            end
            ST_TX: begin
                if (tx_done || tmr_zero) begin
                    state_n   = ST_TAIL;
                    tmr_load  = 1'b1;
                    tmr_value = BIT_LD;
                    timeout_n = !tx_done;
                end
            end
            ST_TAIL: begin
                if (tmr_zero) begin
                    state_n = ST_IDLE;
                    sel_n   = SEL_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                sel_n   = SEL_NONE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= SEL_NONE;
            start_exp   <= 1'b0;
            start_06    <= 1'b0;
            start_03_04 <= 1'b0;
            rs485_oe    <= 1'b0;
            busy        <= 1'b0;
            tx_timeout  <= 1'b0;
            drop_cnt    <= 8'h00;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            start_exp   <= (state_n == ST_START) && (sel_n == SEL_EXP);
            start_06    <= (state_n == ST_START) && (sel_n == SEL_06);
            start_03_04 <= (state_n == ST_START) && (sel_n == SEL_0304);
            rs485_oe    <= (state_n == ST_LEAD) || (state_n == ST_START) ||
                           (state_n == ST_TX)   || (state_n == ST_TAIL);
            busy        <= (state_n != ST_IDLE);
            tx_timeout  <= timeout_n;
            drop_cnt    <= sat_add8(drop_cnt, drop_inc);
        end
    end

endmodule

// File: tb/tb_modbus_rsp_scheduler.sv
// Self-checking bench for modbus_rsp_scheduler with a scaled-down clock/baud so runs stay short.
module tb_modbus_rsp_scheduler;

    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int GB  = 38;
    localparam int MB  = 32;
    localparam int B   = CF / BR;
    localparam int N   = B * GB;
    localparam int TMO = B * 11 * MB;
    localparam int LAT = 1 + B * (GB + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_state = 1'b0;
    logic       req_exp = 1'b0;
    logic       req_06 = 1'b0;
    logic       req_03_04 = 1'b0;
    logic       tx_done = 1'b0;
    logic       start_exp, start_06, start_03_04;
    logic       rs485_oe, busy, tx_timeout;
    logic [7:0] drop_cnt;

    typedef struct {
        int sel;
        int cyc;
    } grant_t;

    grant_t sb[$];
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     exp_drop = 0;
    int     mon_n;
    int     mon_sel;
    grant_t mon_e;

    modbus_rsp_scheduler #(
        .CLK_FREQ  (CF),
        .BAUD_RATE (BR),
        .GAP_BITS  (GB),
        .MAX_BYTES (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_state    (rx_state),
        .req_exp     (req_exp),
        .req_06      (req_06),
        .req_03_04   (req_03_04),
        .tx_done     (tx_done),
        .start_exp   (start_exp),
        .start_06    (start_06),
        .start_03_04 (start_03_04),
        .rs485_oe    (rs485_oe),
        .busy        (busy),
        .tx_timeout  (tx_timeout),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Grant monitor: every start pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_n = int'(start_exp) + int'(start_06) + int'(start_03_04);
            if (mon_n != 0) begin
                total++;
                mon_sel = start_exp ? 0 : (start_06 ? 1 : 2);
                if (mon_n != 1) begin
                    bad++;
                    $display("FAIL grant_onehot cyc=%0d got %0d starts, need 1", cyc, mon_n);
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant cyc=%0d sel=%0d", cyc, mon_sel);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_sel !== mon_e.sel || cyc !== mon_e.cyc) begin
                        bad++;
                        $display("FAIL grant got sel=%0d cyc=%0d need sel=%0d cyc=%0d",
                                 mon_sel, cyc, mon_e.sel, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic add_drop(input int n);
        exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
    endtask

    task automatic push_grant(input int sel, input int at);
        grant_t g;
        g.sel = sel;
        g.cyc = at;
        sb.push_back(g);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rs485_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got %b need 0", rs485_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b need 0", busy); end
        total++; if (drop_cnt !== 8'h00) begin bad++; $display("FAIL reset_drop got %h need 00", drop_cnt); end
        total++; if ({start_exp, start_06, start_03_04} !== 3'b000) begin
            bad++; $display("FAIL reset_start got %b need 000", {start_exp, start_06, start_03_04});
        end
        total++; if (tx_timeout !== 1'b0) begin bad++; $display("FAIL reset_tmo got %b need 0", tx_timeout); end
        rst_n = 1'b1;
        exp_drop = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_06;
        int c, s, d;
        c = cyc;
        s = c + LAT;
        req_06 = 1'b1;
        push_grant(1, s);
        @(negedge clk);
        req_06 = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got %b need 1", busy); end
        go_to(c + 50);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        go_to(c + N);
        total++; if (rs485_oe !== 1'b0) begin bad++; $display("FAIL single_oe_gap got %b need 0", rs485_oe); end
        go_to(c + N + 1);
        total++; if (rs485_oe !== 1'b1) begin bad++; $display("FAIL single_oe_lead got %b need 1", rs485_oe); end
        d = s + 20;
        go_to(d);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        go_to(d + B);
        total++; if (rs485_oe !== 1'b1) begin bad++; $display("FAIL single_oe_tail got %b need 1", rs485_oe); end
        go_to(d + B + 1);
        total++; if (rs485_oe !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_idle got oe=%b busy=%b need 0 0", rs485_oe, busy);
        end
        total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL single_drop got %0d need %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_contention;
        int c, s;
        c = cyc;
        s = c + LAT;
        req_exp = 1'b1;
        req_03_04 = 1'b1;
        push_grant(0, s);
        add_drop(1);
        @(negedge clk);
        req_exp = 1'b0;
        req_03_04 = 1'b0;
        total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL contention_drop got %0d need %0d", drop_cnt, exp_drop); end
        go_to(s + 5);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        go_to(s + 5 + B + 1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL contention_idle got busy=%b need 0", busy); end
    endtask

    task automatic test_rx_restart;
        int c, k2, s;
        c = cyc;
        k2 = c + 202;
        s = k2 + LAT;
        req_06 = 1'b1;
        push_grant(1, s);
        @(negedge clk);
        req_06 = 1'b0;
        go_to(c + 200);
        rx_state = 1'b1;
        go_to(k2 + 1);
        rx_state = 1'b0;
        go_to(c + N + 1);
        total++; if (rs485_oe !== 1'b0) begin bad++; $display("FAIL rx_oe_early got %b need 0", rs485_oe); end
        go_to(k2 + N);
        total++; if (rs485_oe !== 1'b0) begin bad++; $display("FAIL rx_oe_gap got %b need 0", rs485_oe); end
        go_to(k2 + N + 1);
        total++; if (rs485_oe !== 1'b1) begin bad++; $display("FAIL rx_oe_lead got %b need 1", rs485_oe); end
        go_to(s + 3);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        go_to(s + 3 + B + 1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rx_idle got busy=%b need 0", busy); end
    endtask

    task automatic test_timeout;
        int c, s;
        c = cyc;
        s = c + LAT;
        req_exp = 1'b1;
        push_grant(0, s);
        @(negedge clk);
        req_exp = 1'b0;
        go_to(s + TMO);
        total++; if (tx_timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got %b need 0", tx_timeout); end
        go_to(s + TMO + 1);
        total++; if (tx_timeout !== 1'b1 || rs485_oe !== 1'b1) begin
            bad++; $display("FAIL tmo_fire got tmo=%b oe=%b need 1 1", tx_timeout, rs485_oe);
        end
        go_to(s + TMO + 2);
        total++; if (tx_timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse got %b need 0", tx_timeout); end
        go_to(s + TMO + B);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_tail got busy=%b need 1", busy); end
        go_to(s + TMO + B + 1);
        total++; if (busy !== 1'b0 || rs485_oe !== 1'b0) begin
            bad++; $display("FAIL tmo_idle got busy=%b oe=%b need 0 0", busy, rs485_oe);
        end
    endtask

    task automatic test_saturate;
        int c, s;
        c = cyc;
        s = c + LAT;
        req_03_04 = 1'b1;
        push_grant(2, s);
        @(negedge clk);
        req_03_04 = 1'b0;
        go_to(s + 2);
        while (exp_drop < 254) begin
            req_03_04 = 1'b1;
            add_drop(1);
            @(negedge clk);
        end
        req_03_04 = 1'b0;
        total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL sat_fe got %0d need %0d", drop_cnt, exp_drop); end
        req_exp = 1'b1;
        req_06 = 1'b1;
        req_03_04 = 1'b1;
        add_drop(3);
        @(negedge clk);
        req_exp = 1'b0;
        req_06 = 1'b0;
        req_03_04 = 1'b0;
        total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL sat_fe_plus3 got %0d need %0d", drop_cnt, exp_drop); end
        for (int i = 0; i < 46; i++) begin
            req_03_04 = 1'b1;
            add_drop(1);
            @(negedge clk);
        end
        req_03_04 = 1'b0;
        @(negedge clk);
        total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL sat_hold got %0d need %0d", drop_cnt, exp_drop); end
        go_to(s + TMO);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if (tx_timeout !== 1'b0 || rs485_oe !== 1'b1) begin
            bad++; $display("FAIL done_vs_tmo got tmo=%b oe=%b need 0 1", tx_timeout, rs485_oe);
        end
        go_to(s + TMO + B + 1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_idle got busy=%b need 0", busy); end
    endtask

    task automatic test_reset_mid;
        int c, s;
        c = cyc;
        s = c + LAT;
        req_06 = 1'b1;
        push_grant(1, s);
        @(negedge clk);
        req_06 = 1'b0;
        go_to(s + 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_drop = 0;
        total++; if (rs485_oe !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00) begin
            bad++; $display("FAIL mid_reset got oe=%b busy=%b drop=%0d need 0 0 0", rs485_oe, busy, drop_cnt);
        end
        @(negedge clk);
        c = cyc;
        s = c + LAT;
        req_06 = 1'b1;
        push_grant(1, s);
        @(negedge clk);
        req_06 = 1'b0;
        go_to(s + 1);
        total++; if (rs485_oe !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_tx got oe=%b busy=%b need 1 1", rs485_oe, busy);
        end
        go_to(s + 5);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        go_to(s + 5 + B + 1);
        total++; if (busy !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
            bad++; $display("FAIL mid_idle got busy=%b drop=%0d need 0 %0d", busy, drop_cnt, exp_drop);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_06;
        test_contention;
        test_rx_restart;
        test_timeout;
        test_saturate;
        test_reset_mid;
        repeat (5) @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL grants_missing got %0d pending need 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
